// File: rtl/sha256_pad_if.sv
// ---------------------------------------------------------------------------
// sha256_pad_if : byte-stream input and padded-block output of sha256_pad
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sha256_pad_if;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] out_w;
  logic         out_valid;
  logic         err;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, out_w, out_valid, err
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, out_w, out_valid, err
  );
endinterface

`default_nettype wire

// File: rtl/sha256_pad.sv
// ---------------------------------------------------------------------------
// sha256_pad : builds one padded SHA-256 block from a byte stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_pad #(
  parameter int MAX_LEN = 55
) (
  input  wire logic   clk,
  input  wire logic   rst,
  sha256_pad_if.slave bus
);

  localparam logic [5:0] c_MAX_LEN = 6'(MAX_LEN);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EMIT    = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [5:0]   r_cnt, w_cnt_nxt;
  logic [511:0] r_blk, w_blk_nxt;
  logic         r_err, w_err_nxt;

  logic         w_xfer;
  logic [5:0]   w_len;
  logic [8:0]   w_byte_off;
  logic [8:0]   w_pad_off;

  assign w_xfer = bus.s_valid && bus.s_ready;
  assign w_len  = r_cnt + 6'd1;

  // Byte n lands at 32*(n/4) + 8*(3-n%4): big-endian lanes within each word.
  assign w_byte_off = {r_cnt[5:2], ~r_cnt[1:0], 3'b000};
  assign w_pad_off  = {w_len[5:2], ~w_len[1:0], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_cnt   <= '0;
      r_blk   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_blk   <= w_blk_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_blk_nxt   = r_blk;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_xfer) begin
          if (r_cnt < c_MAX_LEN) begin
            w_blk_nxt[w_byte_off +: 8] = bus.s_data;
            w_cnt_nxt                  = w_len;
            if (bus.s_last) begin
              w_blk_nxt[w_pad_off +: 8] = 8'h80;
              w_blk_nxt[479:448]        = 32'd0;
              w_blk_nxt[511:480]        = {23'd0, w_len, 3'd0};
              w_state_nxt               = S_EMIT;
            end
          end else if (bus.s_last) begin
            w_err_nxt = 1'b1;
            w_blk_nxt = '0;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_EMIT: begin
        w_state_nxt = S_COLLECT;
        w_blk_nxt   = '0;
        w_cnt_nxt   = '0;
      end
      S_DRAIN: begin
        if (w_xfer && bus.s_last) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_COLLECT;
          w_blk_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_COLLECT;
        w_blk_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Ready is gated by rst directly so it is low for the whole reset period.
  assign bus.s_ready   = !rst && (r_state != S_EMIT);
  assign bus.out_valid = (r_state == S_EMIT);
  assign bus.out_w     = r_blk;
  assign bus.err       = r_err;

endmodule

`default_nettype wire
